mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_pkg.sv | 29 ++
 rtl/mux4_rr_arbiter_if.sv | 56 +++++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the mux4 round-robin arbiter.
// Optional feature macro: ARB_LOCK_EN (adds the Lock input that suspends the burst limit).
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_CNT_W     = 8;

  localparam logic [1:0] REQ0 = 2'd0;
  localparam logic [1:0] REQ1 = 2'd1;
  localparam logic [1:0] REQ2 = 2'd2;
  localparam logic [1:0] REQ3 = 2'd3;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the mux4 arbiter.
// Optional feature macro: ARB_LOCK_EN (adds Lock, driven by the requester side).
//
// Handshake: Req is a level; Req[i] asks for the mux until it is dropped. Grant
// is registered and one-hot (or zero); a requester owns the mux for every cycle
// its Grant bit is high and must keep Req high to keep ownership. Sel mirrors
// the grant index and holds its last value while Grant is zero.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [3:0] Req;
  logic [3:0] Grant;
  logic [1:0] Sel;
  logic       Busy;
  arb_state_t dbg_state;
`ifdef ARB_LOCK_EN
  logic       Lock;
`endif

`ifdef ARB_LOCK_EN
  modport master (
    output Req,
    output Lock,
    input  Grant,
    input  Sel,
    input  Busy,
    input  dbg_state
  );

  modport slave (
    input  Req,
    input  Lock,
    output Grant,
    output Sel,
    output Busy,
    output dbg_state
  );
`else
  modport master (
    output Req,
    input  Grant,
    input  Sel,
    input  Busy,
    input  dbg_state
  );

  modport slave (
    input  Req,
    output Grant,
    output Sel,
    output Busy,
    output dbg_state
  );
`endif

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or above 'start',
// wrapping modulo 4. Used for both the idle search and the release handoff.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 one-bit mux, with bounded bursts.
// Optional feature macro: ARB_LOCK_EN (Lock input holds the owner past BURST_LEN).
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  mux4_rr_arbiter_if.slave     bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BURST_LEN - 1);

  arb_state_t       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       ptr_q,   ptr_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] pick_start;
  logic       owner_req;
  logic       at_limit;
  logic       lock_hold;
  logic       keep_owner;

  // In OWN the search starts past the owner; in IDLE past the last owner.
  assign pick_start = (state_q == ST_OWN) ? next_idx(sel_q) : next_idx(ptr_q);

  rr_pick4 u_pick (
    .req   (bus.Req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_LOCK_EN
  assign lock_hold = bus.Lock;
`else
  assign lock_hold = 1'b0;
`endif

  // While owning, sel_q is the owner index.
  assign owner_req  = bus.Req[sel_q];
  assign at_limit   = (cnt_q == CNT_LIMIT);
  assign keep_owner = owner_req && (!at_limit || lock_hold);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= REQ0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= REQ3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWN;
          grant_d = idx_to_onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_OWN: begin
        if (keep_owner) begin
          // Saturates at the limit only when Lock is suppressing the release.
          cnt_d = at_limit ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          ptr_d = sel_q;
          // A forced release always finds at least the owner itself.
          if (pick_found) begin
            grant_d = idx_to_onehot(pick_idx);
            sel_d   = pick_idx;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.Grant     = grant_q;
  assign bus.Sel       = sel_q;
  assign bus.Busy      = busy_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: two instances (BURST_LEN 4 and 1)
// driven by the same requests and compared against a cycle-level reference model.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;

  int n_checks = 0;
  int n_err    = 0;

  mux4_rr_arbiter_if if4 ();
  mux4_rr_arbiter_if if1 ();

  assign if4.Req = req;
  assign if1.Req = req;
`ifdef ARB_LOCK_EN
  assign if4.Lock = lock;
  assign if1.Lock = lock;
`endif

  mux4_rr_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut4 (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (if4)
  );

  mux4_rr_arbiter #(.BURST_LEN(1), .CNT_W(8)) dut1 (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (if1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // owner = -1 means nobody holds the mux; held = cycles owned in this burst.
  int         m_owner [2];
  int         m_held  [2];
  int         m_ptr   [2];
  logic [1:0] m_sel   [2];
  int         m_bl    [2] = '{4, 1};

  logic [6:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_ptr[k]   = 3;
      m_sel[k]   = 2'd0;
    end
    exp_q.delete();
  endtask

  // First requester strictly after 'after', wrapping; -1 if none.
  function automatic int first_after(input logic [3:0] r, input int after);
    for (int s = 1; s <= 4; s++) begin
      if (r[(after + s) % 4]) return (after + s) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic l);
    int o;
    int n;
    logic [3:0] g;
    for (int k = 0; k < 2; k++) begin
      o = m_owner[k];
      if (o < 0) begin
        n = first_after(r, m_ptr[k]);
        if (n >= 0) begin
          m_owner[k] = n;
          m_held[k]  = 1;
          m_sel[k]   = 2'(n);
        end
      end else if (r[o] && (m_held[k] < m_bl[k] || l)) begin
        if (m_held[k] < m_bl[k]) m_held[k]++;
      end else begin
        m_ptr[k] = o;
        n = first_after(r, o);
        m_owner[k] = n;
        m_held[k]  = (n >= 0) ? 1 : 0;
        if (n >= 0) m_sel[k] = 2'(n);
      end
      g = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
      exp_q.push_back({(m_owner[k] >= 0), m_sel[k], g});
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic [6:0] e4;
    logic [6:0] e1;
    if (exp_q.size() < 2) begin
      check_val("scoreboard_underflow", 32'(exp_q.size()), 32'd2);
      return;
    end
    e4 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    check_val("bl4_grant", 32'(if4.Grant), 32'(e4[3:0]));
    check_val("bl4_sel",   32'(if4.Sel),   32'(e4[5:4]));
    check_val("bl4_busy",  32'(if4.Busy),  32'(e4[6]));
    check_val("bl1_grant", 32'(if1.Grant), 32'(e1[3:0]));
    check_val("bl1_sel",   32'(if1.Sel),   32'(e1[5:4]));
    check_val("bl1_busy",  32'(if1.Busy),  32'(e1[6]));
    check_val("bl4_onehot0", 32'($onehot0(if4.Grant)), 32'd1);
    check_val("bl1_onehot0", 32'($onehot0(if1.Grant)), 32'd1);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [3:0] r);
    logic l;
    req = r;
    @(posedge clk);
`ifdef ARB_LOCK_EN
    l = lock;
`else
    l = 1'b0;
`endif
    model_step(r, l);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_grant4"}, 32'(if4.Grant), 32'd0);
    check_val({tag, "_sel4"},   32'(if4.Sel),   32'd0);
    check_val({tag, "_busy4"},  32'(if4.Busy),  32'd0);
    check_val({tag, "_grant1"}, 32'(if1.Grant), 32'd0);
    check_val({tag, "_busy1"},  32'(if1.Busy),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 1'b0;
    model_reset();

    // Reset holds everything clear even with all requests high.
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    step(4'b1111);
    check_val("first_grant4", 32'(if4.Grant), 32'h1);
    check_val("first_grant1", 32'(if1.Grant), 32'h1);

    // All requesting: BL4 rotates every 4 cycles, BL1 every cycle.
    for (int i = 0; i < 16; i++) step(4'b1111);

    // Single requester re-granted without gaps, then released to idle.
    for (int i = 0; i < 10; i++) step(4'b0100);
    check_val("single_grant4", 32'(if4.Grant), 32'h4);
    step(4'b0000);
    check_val("idle_sel_hold4", 32'(if4.Sel), 32'd2);
    check_val("idle_grant4", 32'(if4.Grant), 32'd0);

    // Voluntary early release hands off on the next edge.
    do_reset();
    step(4'b0011);
    step(4'b0010);
    check_val("early_release4", 32'(if4.Grant), 32'h2);
    for (int i = 0; i < 5; i++) step(4'b0011);

    // Mid-burst asynchronous reset clears outputs before any clock edge.
    step(4'b0000);
    do_reset();
    step(4'b0100);
    step(4'b0100);
    step(4'b0100);
    #2 rst_n = 1'b0;
    #1 check_cleared("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0101);
    check_val("post_reset_grant4", 32'(if4.Grant), 32'h1);

`ifdef ARB_LOCK_EN
    // Lock keeps the owner past the burst limit; dropping Lock forces release.
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 10; i++) step(4'b0011);
    check_val("lock_hold4", 32'(if4.Grant), 32'h1);
    lock = 1'b0;
    step(4'b0011);
    check_val("lock_release4", 32'(if4.Grant), 32'h2);
`endif

    // Randomized traffic, with sticky requests to exercise full bursts.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else                           r = req;
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
      step(r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
